// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration stream loader.
// Optional checksum trailer is enabled in the RTL by defining CFG_LOADER_CHECKSUM_EN.
package cfg_loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ADDR_BYTES = 4;
    localparam int unsigned DATA_BYTES = 4;
    // One assembler serves address, data and checksum words, so it is sized for the widest
    localparam int unsigned WORD_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int unsigned IDX_W      = $clog2(WORD_BYTES);
    localparam int unsigned CFG_CNT_W  = 16;

    localparam logic [WORD_W-1:0] CFG_IDLE_ADDR = 32'h0000_0000;
    localparam logic [WORD_W-1:0] CFG_END_ADDR  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_END,
        ST_CSUM,
        ST_DONE
    } state_t;

    // Payload broadcast on the configuration bus
    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } cfg_rec_t;

endpackage

// File: rtl/cfg_word_assembler.sv
// Little-endian byte-to-word assembler: first byte lands in bits [7:0].
// word_c/full_c are combinational so the completed word is usable on the accepting edge.
module cfg_word_assembler
    import cfg_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [WORD_W-1:0] word_c,
    output logic              full_c
);

    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] word_q;

    // Insert the incoming byte at the current index; flag the last byte of a word
    always_comb begin
        word_c = word_q;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (load && (idx_q == IDX_W'(i))) begin
                word_c[i*BYTE_W +: BYTE_W] = in_byte;
            end
        end
        full_c = load && (idx_q == IDX_W'(WORD_BYTES - 1));
    end

    // Byte index and partial word; index wraps after each full word
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (clear) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (load) begin
            word_q <= word_c;
            idx_q  <= full_c ? '0 : idx_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/config_stream_loader.sv
// Configuration bus initiator: assembles {addr,data} records from a byte stream
// and broadcasts them as single-cycle config write strobes.
// Define CFG_LOADER_CHECKSUM_EN to require a 4-byte XOR checksum after the terminator.
module config_stream_loader
    import cfg_loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] IDLE_ADDR = CFG_IDLE_ADDR,
    parameter logic [WORD_W-1:0] END_ADDR  = CFG_END_ADDR,
    parameter int unsigned       CNT_W     = CFG_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] config_addr,
    output logic [WORD_W-1:0] config_data,
    output logic              config_strobe,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  write_count
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    cfg_rec_t          cfg_q, cfg_d;
    logic              strobe_q, strobe_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  term_q, term_d;
`ifdef CFG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q, csum_d;
    logic              cnt_bad_q, cnt_bad_d;
`endif

    logic              asm_clear;
    logic              asm_load;
    logic [WORD_W-1:0] asm_word_c;
    logic              asm_full_c;

    assign asm_load = in_valid && ready_q;

    cfg_word_assembler u_asm (
        .clk     (clk),
        .reset   (reset),
        .clear   (asm_clear),
        .load    (asm_load),
        .in_byte (in_byte),
        .word_c  (asm_word_c),
        .full_c  (asm_full_c)
    );

    // Next-state and next-output decode
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cfg_d     = cfg_q;
        strobe_d  = 1'b0;
        done_d    = done_q;
        error_d   = error_q;
        count_d   = count_q;
        term_d    = term_q;
        asm_clear = 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
        cnt_bad_d = cnt_bad_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_ADDR;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    count_d   = '0;
                    asm_clear = 1'b1;
`ifdef CFG_LOADER_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            ST_ADDR: begin
                if (asm_full_c) begin
                    addr_d  = asm_word_c;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (asm_full_c) begin
                    if (addr_q == END_ADDR) begin
                        term_d  = asm_word_c[CNT_W-1:0];
                        state_d = ST_END;
                    end else begin
                        cfg_d.addr = addr_q;
                        cfg_d.data = asm_word_c;
                        strobe_d   = 1'b1;
                        state_d    = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // Data is held after the strobe; only the address returns to idle
                cfg_d.addr = IDLE_ADDR;
                if (count_q != '1) begin
                    count_d = count_q + CNT_W'(1);
                end
`ifdef CFG_LOADER_CHECKSUM_EN
                csum_d = csum_q ^ cfg_q.addr ^ cfg_q.data;
`endif
                state_d = ST_ADDR;
            end
            ST_END: begin
`ifdef CFG_LOADER_CHECKSUM_EN
                cnt_bad_d = (term_q != count_q);
                state_d   = ST_CSUM;
`else
                error_d = (term_q != count_q);
                done_d  = 1'b1;
                state_d = ST_DONE;
`endif
            end
            ST_CSUM: begin
`ifdef CFG_LOADER_CHECKSUM_EN
                if (asm_full_c) begin
                    error_d = cnt_bad_q || (asm_word_c != csum_q);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef CFG_LOADER_CHECKSUM_EN
        ready_d = (state_d == ST_ADDR) || (state_d == ST_DATA) || (state_d == ST_CSUM);
`else
        ready_d = (state_d == ST_ADDR) || (state_d == ST_DATA);
`endif
        busy_d = ready_d || (state_d == ST_WRITE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cfg_q     <= {IDLE_ADDR, WORD_W'(0)};
            strobe_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            count_q   <= '0;
            term_q    <= '0;
`ifdef CFG_LOADER_CHECKSUM_EN
            csum_q    <= '0;
            cnt_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cfg_q     <= cfg_d;
            strobe_q  <= strobe_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            count_q   <= count_d;
            term_q    <= term_d;
`ifdef CFG_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
            cnt_bad_q <= cnt_bad_d;
`endif
        end
    end

    assign in_ready      = ready_q;
    assign config_addr   = cfg_q.addr;
    assign config_data   = cfg_q.data;
    assign config_strobe = strobe_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign write_count   = count_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// Self-checking bench for config_stream_loader (default and CFG_LOADER_CHECKSUM_EN builds).
module tb_config_stream_loader;
    import cfg_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_strobe;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] write_count;

    int checks   = 0;
    int failures = 0;

    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    logic        prev_strobe = 1'b0;

    typedef struct {
        int          n_rec;
        logic [15:0] term;
        int          gap;
        bit          idle_first;
        bit          exp_err;
        logic [15:0] exp_wc;
    } vec_t;

    always #5 clk = ~clk;

    config_stream_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_byte       (in_byte),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .config_addr   (config_addr),
        .config_data   (config_data),
        .config_strobe (config_strobe),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .write_count   (write_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Record every strobe; the cycle after a strobe the address must be back at idle
    always @(negedge clk) begin
        if (prev_strobe && reset) begin
            chk("addr_return", {config_addr, 31'd0, config_strobe}, {CFG_IDLE_ADDR, 32'd0});
        end
        if (config_strobe) obs_q.push_back({config_addr, config_data});
        prev_strobe <= config_strobe;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n;
        bit acc;
        n = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (n) step();
        in_byte  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            acc = in_ready;
            step();
            if (acc) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                return;
            end
        end
        in_valid = 1'b0;
        chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], max_gap);
    endtask

    task automatic send_rec(input logic [31:0] a, input logic [31:0] d, input int max_gap);
        send_word(a, max_gap);
        send_word(d, max_gap);
    endtask

    task automatic wait_done();
        for (int t = 0; t < 40 && !done; t++) step();
        chk("done_set", 64'(done), 64'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_addr_data"}, {config_addr, config_data}, {CFG_IDLE_ADDR, 32'd0});
        chk({tag, "_ctrl"}, 64'({config_strobe, in_ready, busy, done, error, write_count}), 64'(0));
    endtask

    // Terminator (and checksum when enabled) carrying the given count
    task automatic finish_stream(input logic [15:0] term, input logic [31:0] csum, input int gap);
        send_rec(CFG_END_ADDR, {16'd0, term}, gap);
`ifdef CFG_LOADER_CHECKSUM_EN
        send_word(csum, gap);
`else
        if (csum == 32'd0) in_byte = 8'd0;
`endif
    endtask

    // Random records; the model is the ordered list of non-terminator records and their XOR
    task automatic run_stream(input int n_rec, input logic [15:0] term, input int gap, input bit idle_first);
        logic [31:0] a, d, csum;
        csum = '0;
        exp_q.delete();
        pulse_start();
        obs_q.delete();
        chk("start_clears", 64'({done, error, busy, in_ready, write_count}), 64'({4'b0011, 16'd0}));
        for (int i = 0; i < n_rec; i++) begin
            a = $urandom & 32'hFFFF_FFFE;
            if (idle_first && i == 0) a = CFG_IDLE_ADDR;
            d = $urandom;
            send_rec(a, d, gap);
            exp_q.push_back({a, d});
            csum = csum ^ a ^ d;
        end
        finish_stream(term, csum, gap);
        wait_done();
        step();
        chk("n_writes", 64'(obs_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) chk("write_rec", obs_q[i], exp_q[i]);
        end
        chk("done_idle", {config_addr, 29'd0, busy, in_ready, config_strobe}, {CFG_IDLE_ADDR, 32'd0});
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{n_rec: 0, term: 16'd0,      gap: 0, idle_first: 0, exp_err: 0, exp_wc: 16'd0};
        vecs[1] = '{n_rec: 1, term: 16'd1,      gap: 0, idle_first: 0, exp_err: 0, exp_wc: 16'd1};
        vecs[2] = '{n_rec: 2, term: 16'd2,      gap: 2, idle_first: 1, exp_err: 0, exp_wc: 16'd2};
        vecs[3] = '{n_rec: 2, term: 16'd3,      gap: 1, idle_first: 0, exp_err: 1, exp_wc: 16'd2};
        vecs[4] = '{n_rec: 3, term: 16'd0,      gap: 3, idle_first: 0, exp_err: 1, exp_wc: 16'd3};
        vecs[5] = '{n_rec: 4, term: 16'd4,      gap: 1, idle_first: 1, exp_err: 0, exp_wc: 16'd4};
        vecs[6] = '{n_rec: 1, term: 16'hFFFF,   gap: 0, idle_first: 0, exp_err: 1, exp_wc: 16'd1};

        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'd0;
        repeat (2) step();
        check_reset_vals("reset");
        reset = 1'b1;
        step();
        chk("idle_no_ready", 64'({busy, in_ready}), 64'(0));

        // Back-to-back single record, exact latency
        pulse_start();
        send_rec(32'h0005_0001, 32'hDEAD_BEEF, 0);
        chk("strobe_cycle", {config_addr, config_data}, {32'h0005_0001, 32'hDEAD_BEEF});
        chk("strobe_ctrl", 64'({config_strobe, in_ready, write_count}), 64'({2'b10, 16'd0}));
        step();
        chk("after_write", {config_addr, config_data}, {32'h0000_0000, 32'hDEAD_BEEF});
        chk("after_ctrl", 64'({config_strobe, write_count}), 64'({1'b0, 16'd1}));

        // Reset in the middle of the data word discards the partial record
        send_word(32'h0007_0002, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        reset = 1'b0;
        step();
        check_reset_vals("mid_reset");
        reset = 1'b1;
        pulse_start();
        send_rec(32'h0002_0003, 32'h1234_5678, 0);
        chk("post_reset_rec", {config_addr, config_data}, {32'h0002_0003, 32'h1234_5678});
        chk("post_reset_strobe", 64'(config_strobe), 64'(1));

        // Gapped valid with a 3-cycle hole mid-address and a stray start
        reset = 1'b0;
        step();
        reset = 1'b1;
        pulse_start();
        obs_q.delete();
        send_byte(8'h11, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        send_byte(8'h22, 1);
        send_byte(8'h33, 2);
        send_byte(8'h44, 1);
        send_word(32'hCAFE_F00D, 2);
        step();
        chk("gap_count", 64'(obs_q.size()), 64'(1));
        if (obs_q.size() > 0) chk("gap_rec", obs_q[0], {32'h4433_2211, 32'hCAFE_F00D});
        finish_stream(16'd1, 32'h4433_2211 ^ 32'hCAFE_F00D, 1);
        wait_done();
        chk("gap_result", 64'({error, write_count}), 64'({1'b0, 16'd1}));

        // Table of streams with random record contents
        for (int v = 0; v < 7; v++) begin
            run_stream(vecs[v].n_rec, vecs[v].term, vecs[v].gap, vecs[v].idle_first);
            chk($sformatf("vec%0d_err", v), 64'(error), 64'(vecs[v].exp_err));
            chk($sformatf("vec%0d_wc", v), 64'(write_count), 64'(vecs[v].exp_wc));
        end

`ifdef CFG_LOADER_CHECKSUM_EN
        begin : csum_test
            logic [31:0] cs_word [2];
            bit          cs_err  [2];
            cs_word[0] = 32'h0001_00FE;
            cs_word[1] = 32'h0000_0000;
            cs_err[0]  = 1'b0;
            cs_err[1]  = 1'b1;
            for (int k = 0; k < 2; k++) begin
                pulse_start();
                send_rec(32'h0001_0001, 32'h0000_00FF, 0);
                send_rec(CFG_END_ADDR, 32'd1, 0);
                step();
                chk("csum_wait_state", 64'({done, in_ready, busy}), 64'({3'b011}));
                send_word(cs_word[k], 0);
                wait_done();
                chk($sformatf("csum%0d_err", k), 64'(error), 64'(cs_err[k]));
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
